// File: rtl/dmx_pkg.sv
// dmx_pkg: register map, FSM encoding and limits shared by the DMX512 transmitter
package dmx_pkg;
  localparam int DMX_MAX_SLOTS = 512;
  localparam int DMX_BITS_PER_SLOT = 11;
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_NSLOTS = 2'd2;
  localparam logic [1:0] REG_START_CODE = 2'd3;
  localparam int CTRL_START = 0;
  localparam int CTRL_CONT = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  typedef enum logic [2:0] {S_IDLE, S_BREAK, S_MAB, S_START, S_DATA, S_STOP} dmx_state_e;
  function automatic logic [9:0] clamp_nslots(input logic [31:0] v);
    return v == 32'd0 ? 10'd1 : v > 32'(DMX_MAX_SLOTS) ? 10'(DMX_MAX_SLOTS) : v[9:0];
  endfunction
endpackage

// File: rtl/wb_dmx_tx_if.sv
// wb_dmx_tx_if: Wishbone slave bundle for the DMX512 transmitter
interface wb_dmx_tx_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0] wb_sel_i;
  logic wb_stb_i;
  logic wb_cyc_i;
  logic wb_we_i;
  logic wb_ack_o;
  modport master(output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i, input wb_dat_o, wb_ack_o);
  modport slave(input wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i, output wb_dat_o, wb_ack_o);
endinterface

// File: rtl/dmx_slot_ram.sv
// dmx_slot_ram: 128x32 slot buffer with a byte-writable bus port and a serializer read port
module dmx_slot_ram (
  input logic clk,
  input logic a_we,
  input logic [3:0] a_be,
  input logic [6:0] a_adr,
  input logic [31:0] a_wdat,
  output logic [31:0] a_rdat,
  input logic [6:0] b_adr,
  output logic [31:0] b_rdat
);
  logic [31:0] mem [128];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (a_we && a_be[i]) mem[a_adr][8*i +: 8] <= a_wdat[8*i +: 8];
  assign a_rdat = mem[a_adr];
  assign b_rdat = mem[b_adr];
endmodule

// File: rtl/wb_dmx_tx.sv
// wb_dmx_tx: Wishbone DMX512 transmitter; define DMX_TX_IRQ_EN to enable the frame-done interrupt
module wb_dmx_tx import dmx_pkg::*; #(
  parameter int clk_freq = 100000000,
  parameter int baud = 250000,
  parameter int break_bits = 23,
  parameter int mab_bits = 3
) (
  input logic clk,
  input logic reset,
  wb_dmx_tx_if.slave wb,
  output logic dmx_txd,
  output logic dmx_de,
  output logic intr
);
  localparam int CPB = clk_freq / baud;
  localparam int TW = $clog2(CPB + 1);
  dmx_state_e state, state_nx;
  logic [TW-1:0] timer;
  logic [7:0] bit_cnt;
  logic [9:0] slot_idx, nslots, nslots_lat;
  logic [8:0] buf_byte;
  logic [7:0] start_code, shreg, slot_byte;
  logic [31:0] ram_a, ram_b, reg_rdat;
  logic cont, irq_en, done;
  logic acc, wr, reg_wr, start_wr, done_clr, tick, frame_end;
  logic unused_adr;
  assign unused_adr = ^{wb.wb_adr_i[31:12], wb.wb_adr_i[10:9], wb.wb_adr_i[1:0]};
  assign acc = wb.wb_stb_i & wb.wb_cyc_i & ~wb.wb_ack_o;
  assign wr = acc & wb.wb_we_i;
  assign reg_wr = wr & ~wb.wb_adr_i[11];
  assign start_wr = reg_wr && wb.wb_adr_i[3:2] == REG_CTRL && wb.wb_dat_i[CTRL_START];
  assign done_clr = reg_wr && wb.wb_adr_i[3:2] == REG_STATUS && wb.wb_dat_i[STAT_DONE];
  assign tick = timer == TW'(CPB - 1);
  assign buf_byte = 9'(slot_idx - 10'd1);
  assign slot_byte = slot_idx == 10'd0 ? start_code : 8'(ram_b >> {~buf_byte[1:0], 3'b000});
  dmx_slot_ram u_ram (
    .clk(clk),
    .a_we(wr & wb.wb_adr_i[11]),
    .a_be(wb.wb_sel_i),
    .a_adr(wb.wb_adr_i[8:2]),
    .a_wdat(wb.wb_dat_i),
    .a_rdat(ram_a),
    .b_adr(buf_byte[8:2]),
    .b_rdat(ram_b)
  );
  always_ff @(posedge clk)
    if (reset) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    frame_end = 1'b0;
    case (state)
      S_IDLE: state_nx = start_wr ? S_BREAK : S_IDLE;
      S_BREAK: state_nx = tick && bit_cnt == 8'(break_bits - 1) ? S_MAB : S_BREAK;
      S_MAB: state_nx = tick && bit_cnt == 8'(mab_bits - 1) ? S_START : S_MAB;
      S_START: state_nx = tick ? S_DATA : S_START;
      S_DATA: state_nx = tick && bit_cnt == 8'd8 ? S_STOP : S_DATA;
      S_STOP:
        if (tick && bit_cnt == 8'(DMX_BITS_PER_SLOT - 1)) begin
          frame_end = slot_idx == nslots_lat;
          state_nx = !frame_end ? S_START : cont ? S_BREAK : S_IDLE;
        end
      default: state_nx = S_IDLE;
    endcase
  end
  always_comb begin
    dmx_de = state != S_IDLE;
    dmx_txd = !(state == S_BREAK || state == S_START || (state == S_DATA && !shreg[0]));
  end
  always_ff @(posedge clk)
    if (reset) begin
      timer <= '0;
      bit_cnt <= '0;
      slot_idx <= '0;
      nslots_lat <= '0;
      shreg <= '0;
    end else begin
      timer <= state == S_IDLE || tick ? '0 : timer + 1'b1;
      if (state == S_IDLE) bit_cnt <= '0;
      else if (tick) bit_cnt <= state_nx != state && state != S_START && state != S_DATA ? '0 : bit_cnt + 1'b1;
      if (state == S_MAB) slot_idx <= '0;
      else if (state == S_STOP && state_nx == S_START) slot_idx <= slot_idx + 1'b1;
      if (state_nx == S_BREAK && state != S_BREAK) nslots_lat <= nslots;
      if (tick && state == S_START) shreg <= slot_byte;
      else if (tick && state == S_DATA) shreg <= shreg >> 1;
    end
  always_comb begin
    reg_rdat = '0;
    case (wb.wb_adr_i[3:2])
      REG_CTRL: begin
        reg_rdat[CTRL_CONT] = cont;
        reg_rdat[CTRL_IRQ_EN] = irq_en;
      end
      REG_STATUS: begin
        reg_rdat[STAT_BUSY] = state != S_IDLE;
        reg_rdat[STAT_DONE] = done;
      end
      REG_NSLOTS: reg_rdat[9:0] = nslots;
      REG_START_CODE: reg_rdat[7:0] = start_code;
      default: reg_rdat = '0;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= '0;
      nslots <= 10'(DMX_MAX_SLOTS);
      start_code <= '0;
      cont <= 1'b0;
      done <= 1'b0;
    end else begin
      wb.wb_ack_o <= acc;
      wb.wb_dat_o <= acc && !wb.wb_we_i ? (wb.wb_adr_i[11] ? ram_a : reg_rdat) : '0;
      if (reg_wr && wb.wb_adr_i[3:2] == REG_CTRL) cont <= wb.wb_dat_i[CTRL_CONT];
      if (reg_wr && wb.wb_adr_i[3:2] == REG_NSLOTS) nslots <= clamp_nslots(wb.wb_dat_i);
      if (reg_wr && wb.wb_adr_i[3:2] == REG_START_CODE) start_code <= wb.wb_dat_i[7:0];
      done <= frame_end | (done & ~done_clr);
    end
`ifdef DMX_TX_IRQ_EN
  always_ff @(posedge clk)
    if (reset) irq_en <= 1'b0;
    else if (reg_wr && wb.wb_adr_i[3:2] == REG_CTRL) irq_en <= wb.wb_dat_i[CTRL_IRQ_EN];
  assign intr = done & irq_en;
`else
  assign irq_en = 1'b0;
  assign intr = 1'b0;
`endif
endmodule
